snake_segment_renderer: RTL and testbench

SNAKE_SEGMENT_RENDERER -- requirements
Module: snake_segment_renderer

---
 rtl/snake_segment_renderer.sv | 200 ++++++++++++++++++++
 tb/tb_snake_segment_renderer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_segment_renderer.sv
// Snake board renderer: shadows the game state once per frame, then
// classifies each pixel against head, body, food and optional grid
// (grid lines enabled with macro SNAKE_RENDER_GRID_EN).
module snake_segment_renderer #(
    parameter int MAX_SEGMENTS = 80,
    parameter int COORD_W      = 20,
    parameter int TILE_SIZE    = 40,
    parameter int BOARD_X0     = 48,
    parameter int BOARD_Y0     = 48,
    parameter int GRID_W       = 10,
    parameter int GRID_H       = 10
) (
    input  logic                              clk25,
    input  logic                              reset,
    input  logic [31:0]                       x,
    input  logic [31:0]                       y,
    input  logic                              active,
    input  logic                              screenEnd,
    input  logic [MAX_SEGMENTS*COORD_W-1:0]   x_values,
    input  logic [MAX_SEGMENTS*COORD_W-1:0]   y_values,
    input  logic [$clog2(MAX_SEGMENTS+1)-1:0] seg_count,
    input  logic [COORD_W-1:0]                food_x,
    input  logic [COORD_W-1:0]                food_y,
    input  logic                              game_done,
    input  logic [11:0]                       bg_color,
    output logic [11:0]                       color_out,
    output logic                              color_valid
);

    localparam int CNT_W = $clog2(MAX_SEGMENTS + 1);
    localparam int VEC_W = MAX_SEGMENTS * COORD_W;

    localparam logic [31:0] X_LO  = 32'(BOARD_X0);
    localparam logic [31:0] Y_LO  = 32'(BOARD_Y0);
    localparam logic [31:0] X_HI  = 32'(BOARD_X0 + GRID_W * TILE_SIZE);
    localparam logic [31:0] Y_HI  = 32'(BOARD_Y0 + GRID_H * TILE_SIZE);
    localparam logic [31:0] TILE  = 32'(TILE_SIZE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SEGMENTS);

    localparam logic [11:0] C_HEAD  = 12'h0F0;
    localparam logic [11:0] C_BODY  = 12'h080;
    localparam logic [11:0] C_FOOD  = 12'hF00;
    localparam logic [11:0] C_GRID  = 12'h444;
    localparam logic [11:0] C_BLINK = 12'hF80;

    typedef enum logic [2:0] {
        CLS_BG   = 3'd0,
        CLS_HEAD = 3'd1,
        CLS_BODY = 3'd2,
        CLS_FOOD = 3'd3,
        CLS_GRID = 3'd4
    } cls_e;

    // Shadow copy of the game state, frozen for the whole frame
    logic [VEC_W-1:0]   xs_q, xs_d;
    logic [VEC_W-1:0]   ys_q, ys_d;
    logic [COORD_W-1:0] fx_q, fx_d;
    logic [COORD_W-1:0] fy_q, fy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         frame_q, frame_d;

    // Stage 1: pixel class plus the data needed to colour it
    cls_e               cls1_q, cls1_d;
    logic               blink1_q, blink1_d;
    logic               act1_q, act1_d;
    logic [11:0]        bg1_q, bg1_d;

    // Stage 2: final pixel
    logic [11:0]        color_q, color_d;
    logic               valid_q, valid_d;

    // Pixel geometry and hit flags
    logic [31:0]        dx;
    logic [31:0]        dy;
    logic [31:0]        col;
    logic [31:0]        row;
    logic               in_board;
    logic               head_hit;
    logic               body_hit;
    logic               food_hit;
    logic               grid_hit;

    // Snapshot game state and advance the frame counter on screenEnd
    always_comb begin
        xs_d    = xs_q;
        ys_d    = ys_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        if (screenEnd) begin
            xs_d    = x_values;
            ys_d    = y_values;
            fx_d    = food_x;
            fy_d    = food_y;
            cnt_d   = (seg_count > CNT_MAX) ? CNT_MAX : seg_count;
            frame_d = frame_q + 4'd1;
        end
    end

    // Locate the pixel on the board; uses the pre-snapshot shadow
    always_comb begin
        dx       = x - X_LO;
        dy       = y - Y_LO;
        in_board = (x >= X_LO) && (x < X_HI) &&
                   (y >= Y_LO) && (y < Y_HI);
        col      = dx / TILE;
        row      = dy / TILE;
        head_hit = 1'b0;
        body_hit = 1'b0;
        for (int k = 0; k < MAX_SEGMENTS; k++) begin
            if ((k < int'(cnt_q)) &&
                (col == 32'(xs_q[k*COORD_W +: COORD_W])) &&
                (row == 32'(ys_q[k*COORD_W +: COORD_W]))) begin
                if (k == 0) begin
                    head_hit = 1'b1;
                end else begin
                    body_hit = 1'b1;
                end
            end
        end
        food_hit = (col == 32'(fx_q)) && (row == 32'(fy_q));
`ifdef SNAKE_RENDER_GRID_EN
        grid_hit = ((dx % TILE) == 32'd0) || ((dy % TILE) == 32'd0);
`else
        grid_hit = 1'b0;
`endif
    end

    // Stage 1: resolve draw priority for this pixel
    always_comb begin
        cls1_d   = CLS_BG;
        blink1_d = game_done & frame_q[3];
        act1_d   = active;
        bg1_d    = bg_color;
        if (in_board) begin
            if (head_hit) begin
                cls1_d = CLS_HEAD;
            end else if (body_hit) begin
                cls1_d = CLS_BODY;
            end else if (food_hit) begin
                cls1_d = CLS_FOOD;
            end else if (grid_hit) begin
                cls1_d = CLS_GRID;
            end else begin
                cls1_d = CLS_BG;
            end
        end
    end

    // Stage 2: map the class to RGB444, blanking outside active video
    always_comb begin
        color_d = 12'h000;
        valid_d = act1_q;
        if (act1_q) begin
            unique case (cls1_q)
                CLS_HEAD: color_d = blink1_q ? C_BLINK : C_HEAD;
                CLS_BODY: color_d = blink1_q ? C_BLINK : C_BODY;
                CLS_FOOD: color_d = C_FOOD;
                CLS_GRID: color_d = C_GRID;
                default:  color_d = bg1_q;
            endcase
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            xs_q     <= '0;
            ys_q     <= '0;
            fx_q     <= '0;
            fy_q     <= '0;
            cnt_q    <= '0;
            frame_q  <= '0;
            cls1_q   <= CLS_BG;
            blink1_q <= 1'b0;
            act1_q   <= 1'b0;
            bg1_q    <= '0;
            color_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            cls1_q   <= cls1_d;
            blink1_q <= blink1_d;
            act1_q   <= act1_d;
            bg1_q    <= bg1_d;
            color_q  <= color_d;
            valid_q  <= valid_d;
        end
    end

    assign color_out   = color_q;
    assign color_valid = valid_q;

endmodule

// File: tb/tb_snake_segment_renderer.sv
// Randomised bench for snake_segment_renderer against a per-frame
// reference model of the board drawn from the segment list.
module tb_snake_segment_renderer;

    localparam int MS   = 80;
    localparam int CW   = 20;
    localparam int CNTW = 7;

    logic              clk25 = 1'b0;
    logic              reset;
    logic [31:0]       x, y;
    logic              active, screenEnd;
    logic [MS*CW-1:0]  x_values, y_values;
    logic [CNTW-1:0]   seg_count;
    logic [CW-1:0]     food_x, food_y;
    logic              game_done;
    logic [11:0]       bg_color;
    logic [11:0]       color_out;
    logic              color_valid;

    always #20 clk25 = ~clk25;

    snake_segment_renderer dut (
        .clk25       (clk25),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .active      (active),
        .screenEnd   (screenEnd),
        .x_values    (x_values),
        .y_values    (y_values),
        .seg_count   (seg_count),
        .food_x      (food_x),
        .food_y      (food_y),
        .game_done   (game_done),
        .bg_color    (bg_color),
        .color_out   (color_out),
        .color_valid (color_valid)
    );

    // Game state as the game logic would present it
    int sx[MS];
    int sy[MS];
    int s_cnt, s_fx, s_fy;

    // Model: what the renderer has latched for the current frame
    int m_x[MS];
    int m_y[MS];
    int m_cnt, m_fx, m_fy, m_frame;

    int          n_checks;
    int          n_pass;
    string       cur_tag;
    logic [11:0] prev_c;
    logic        prev_v;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic pack();
        for (int k = 0; k < MS; k++) begin
            x_values[k*CW +: CW] = CW'(sx[k]);
            y_values[k*CW +: CW] = CW'(sy[k]);
        end
        seg_count = CNTW'(s_cnt);
        food_x    = CW'(s_fx);
        food_y    = CW'(s_fy);
    endtask

    function automatic logic [11:0] model_color(logic [31:0] px,
                                                logic [31:0] py,
                                                logic act,
                                                logic gd,
                                                logic [11:0] bg);
        int col, row;
        logic blink;
        if (!act) return 12'h000;
        if (px < 48 || px >= 448 || py < 48 || py >= 448) return bg;
        col   = int'((px - 48) / 40);
        row   = int'((py - 48) / 40);
        blink = gd && (m_frame >= 8);
        for (int k = 0; k < m_cnt; k++) begin
            if (m_x[k] == col && m_y[k] == row) begin
                if (blink) return 12'hF80;
                return (k == 0) ? 12'h0F0 : 12'h080;
            end
        end
        if (m_fx == col && m_fy == row) return 12'hF00;
`ifdef SNAKE_RENDER_GRID_EN
        if ((px - 48) % 40 == 0 || (py - 48) % 40 == 0) return 12'h444;
`endif
        return bg;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < MS; k++) begin
            m_x[k] = 0;
            m_y[k] = 0;
        end
        m_cnt   = 0;
        m_fx    = 0;
        m_fy    = 0;
        m_frame = 0;
        prev_c  = 12'h000;
        prev_v  = 1'b0;
    endtask

    // One pixel clock: drive, predict, clock, check the pixel from
    // the previous edge (two edges after it was sampled).
    task automatic step(logic [31:0] px, logic [31:0] py,
                        logic act, logic se);
        logic [11:0] e;
        x         = px;
        y         = py;
        active    = act;
        screenEnd = se;
        bg_color  = 12'($urandom);
        pack();
        e = model_color(px, py, act, game_done, bg_color);
        if (se) begin
            for (int k = 0; k < MS; k++) begin
                m_x[k] = sx[k];
                m_y[k] = sy[k];
            end
            m_cnt   = (s_cnt > MS) ? MS : s_cnt;
            m_fx    = s_fx;
            m_fy    = s_fy;
            m_frame = (m_frame + 1) % 16;
        end
        @(posedge clk25);
        @(negedge clk25);
        check({cur_tag, ".color"}, 32'(color_out), 32'(prev_c));
        check({cur_tag, ".valid"}, 32'(color_valid), 32'(prev_v));
        prev_c = e;
        prev_v = act;
    endtask

    task automatic tile_px(int c, int r, output logic [31:0] px,
                           output logic [31:0] py);
        px = 32'(48 + c * 40 + int'($urandom_range(0, 39)));
        py = 32'(48 + r * 40 + int'($urandom_range(0, 39)));
    endtask

    task automatic rand_px(output logic [31:0] px, output logic [31:0] py);
        int m;
        m = int'($urandom_range(0, 9));
        if (m < 5) begin
            tile_px(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                    px, py);
        end else if (m < 7) begin
            px = 32'(48 + 40 * int'($urandom_range(0, 10)));
            py = 32'(48 + 40 * int'($urandom_range(0, 10)));
        end else if (m < 9) begin
            px = 32'($urandom_range(0, 520));
            py = 32'($urandom_range(0, 520));
        end else begin
            px = $urandom;
            py = $urandom;
        end
    endtask

    task automatic rand_state();
        for (int k = 0; k < MS; k++) begin
            sx[k] = int'($urandom_range(0, 11));
            sy[k] = int'($urandom_range(0, 11));
        end
        s_cnt = int'($urandom_range(0, 90));
        s_fx  = int'($urandom_range(0, 10));
        s_fy  = int'($urandom_range(0, 10));
    endtask

    initial begin
        logic [31:0] px, py;
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        x         = '0;
        y         = '0;
        active    = 1'b0;
        screenEnd = 1'b0;
        game_done = 1'b0;
        bg_color  = 12'h000;
        for (int k = 0; k < MS; k++) begin
            sx[k] = 0;
            sy[k] = 0;
        end
        s_cnt = 0;
        s_fx  = 0;
        s_fy  = 0;
        pack();
        model_reset();
        cur_tag = "reset";
        #1;
        check("reset.color", 32'(color_out), 32'h0);
        check("reset.valid", 32'(color_valid), 32'h0);
        @(negedge clk25);
        @(negedge clk25);
        reset = 1'b1;

        // Active pixels straight after reset, no snapshot yet
        cur_tag = "post_reset";
        for (int i = 0; i < 6; i++) begin
            rand_px(px, py);
            step(px, py, 1'b1, 1'b0);
        end

        // Three-segment snake along the top row
        cur_tag = "basic";
        s_cnt = 3;
        sx[0] = 0; sy[0] = 0;
        sx[1] = 1; sy[1] = 0;
        sx[2] = 2; sy[2] = 0;
        s_fx  = 6; s_fy  = 6;
        step(32'd0, 32'd0, 1'b0, 1'b1);
        step(32'd48, 32'd48, 1'b1, 1'b0);
        step(32'd88, 32'd48, 1'b1, 1'b0);
        step(32'd128, 32'd60, 1'b1, 1'b0);
        step(32'd170, 32'd48, 1'b1, 1'b0);

        // Game state moves without screenEnd: old frame keeps drawing
        cur_tag = "hold";
        sx[0] = 7; sy[0] = 7;
        sx[1] = 8; sy[1] = 7;
        s_cnt = 2;
        step(32'd48, 32'd48, 1'b1, 1'b0);
        step(32'd128, 32'd48, 1'b1, 1'b0);
        step(32'd340, 32'd340, 1'b1, 1'b0);
        step(32'd0, 32'd0, 1'b1, 1'b1);
        step(32'd48, 32'd48, 1'b1, 1'b0);
        step(32'd340, 32'd340, 1'b1, 1'b0);

        // Head over food, and the first column past the board
        cur_tag = "overlap";
        sx[0] = 4; sy[0] = 4;
        s_fx  = 4; s_fy  = 4;
        step(32'd0, 32'd0, 1'b1, 1'b1);
        step(32'd208, 32'd208, 1'b1, 1'b0);
        step(32'd448, 32'd48, 1'b1, 1'b0);
        step(32'd47, 32'd100, 1'b1, 1'b0);
        step(32'd100, 32'd448, 1'b1, 1'b0);

        // Oversized count clamps; all 80 slots render
        cur_tag = "clamp";
        rand_state();
        s_cnt = 90;
        step(32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            int k;
            k = (i == 0) ? MS - 1 : int'($urandom_range(0, MS - 1));
            tile_px(sx[k], sy[k], px, py);
            step(px, py, 1'b1, 1'b0);
        end

        // Live-count boundary: slot 5 unused when count is 5
        cur_tag = "count5";
        for (int k = 0; k < MS; k++) begin
            sx[k] = 11;
            sy[k] = 11;
        end
        for (int k = 0; k < 6; k++) begin
            sx[k] = k;
            sy[k] = 9;
        end
        s_cnt = 5;
        s_fx  = 9; s_fy = 0;
        step(32'd0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tile_px(k, 9, px, py);
            step(px, py, 1'b1, 1'b0);
        end

        // Empty snake: food only
        cur_tag = "count0";
        s_cnt = 0;
        step(32'd0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tile_px(k, 9, px, py);
            step(px, py, 1'b1, 1'b0);
        end
        tile_px(9, 0, px, py);
        step(px, py, 1'b1, 1'b0);

        // Game over blinking over 16 frames
        cur_tag = "blink";
        s_cnt = 3;
        sx[0] = 2; sy[0] = 2;
        sx[1] = 3; sy[1] = 2;
        sx[2] = 4; sy[2] = 2;
        s_fx  = 5; s_fy = 5;
        game_done = 1'b1;
        for (int f = 0; f < 17; f++) begin
            step(32'd0, 32'd0, 1'b0, 1'b1);
            tile_px(2, 2, px, py);
            step(px, py, 1'b1, 1'b0);
            tile_px(3, 2, px, py);
            step(px, py, 1'b1, 1'b0);
            tile_px(5, 5, px, py);
            step(px, py, 1'b1, 1'b0);
        end
        game_done = 1'b0;

        // Randomised frames
        cur_tag = "random";
        rand_state();
        for (int i = 0; i < 600; i++) begin
            logic se, act;
            se  = ($urandom_range(0, 24) == 0);
            act = ($urandom_range(0, 3) != 0);
            if (se || $urandom_range(0, 40) == 0) rand_state();
            if ($urandom_range(0, 50) == 0) game_done = ~game_done;
            rand_px(px, py);
            step(px, py, act, se);
        end

        // Reset in the middle of a line of head pixels
        cur_tag = "midreset";
        game_done = 1'b0;
        s_cnt = 1;
        sx[0] = 1; sy[0] = 1;
        step(32'd0, 32'd0, 1'b0, 1'b1);
        tile_px(1, 1, px, py);
        step(px, py, 1'b1, 1'b0);
        step(px, py, 1'b1, 1'b0);
        @(posedge clk25);
        #5;
        reset = 1'b0;
        #1;
        check("midreset.color_now", 32'(color_out), 32'h0);
        check("midreset.valid_now", 32'(color_valid), 32'h0);
        @(negedge clk25);
        check("midreset.color_hold", 32'(color_out), 32'h0);
        model_reset();
        reset = 1'b1;
        cur_tag = "resume";
        for (int i = 0; i < 8; i++) begin
            tile_px(1, 1, px, py);
            step(px, py, 1'b1, 1'b0);
        end
        step(32'd0, 32'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
